ordered_dynamic_alu: RTL
========================

// Module: ordered_dynamic_alu
// PURPOSE
// Latency-insensitive integer ALU (add/sub/mul) with a ready-valid interface on both sides.
// Gives strict in-order completion via an internal reorder buffer (ROB), regardless of unit latency.
// Parametrised in width, per-unit pipeline depth and ROB depth.
// Sits between the operand issue stage and the result consumer. Never stalls its internal pipelines.
// PARAMETERS
// WIDTH       32  operand/result width in bits (>=2)
// ADD_STAGES  2   adder/subtractor pipeline latency in cycles (>=1)
// MUL_STAGES  3   multiplier pipeline latency in cycles (>=1)
// ROB_DEPTH   8   reorder-buffer slots = max ops in flight; power of 2, >=2
// PORTS
// clk        in   1      clock; all state on rising edge
// reset      in   1      asynchronous, active-low reset
// operand_a  in   WIDTH  first operand
// operand_b  in   WIDTH  second operand
// operation  in   2      00 add, 01 sub (a-b), 10 mul (unsigned), 11 reserved
// valid_in   in   1      input op valid
// ready_out  out  1      can accept an op this cycle
// result     out  WIDTH  result of oldest completed op
// op_out     out  2      operation code of the op on result
// overflow   out  1      add/sub: signed overflow; mul: full product >= 2**WIDTH
// illegal    out  1      op was 11; result forced to 0, overflow 0
// valid_out  out  1      result/op_out/overflow/illegal valid
// ready_in   in   1      consumer accepts output
// in_flight  out  log2(ROB_DEPTH)+1  occupied ROB slots
// BEHAVIOUR
// - Reset (reset=0, async): head=tail=0, in_flight=0, all done bits and pipeline valids 0.
//   On reset: ready_out=0, valid_out=0, result/op_out/overflow/illegal=0.
//   ready_out rises in the first cycle after reset deasserts.
//   Reset mid-operation discards all in-flight ops silently.
// - ready_out = (in_flight < ROB_DEPTH); independent of valid_in and operation.
// - Accept = valid_in & ready_out. The accepted op takes tag = tail, and tail increments mod ROB_DEPTH.
//   Routing: add, sub and reserved ops go to the add pipe; mul goes to the mul pipe.
// - Pipes are non-stalling shift registers carrying {valid, tag, op, result, ovf}.
//   Arithmetic wraps modulo 2**WIDTH.
// - Op accepted at edge n completes at edge n+ADD_STAGES (add pipe) or n+MUL_STAGES (mul pipe).
//   Completion writes ROB[tag] and sets done[tag].
//   Both pipes may complete on the same edge; their tags always differ, so both writes occur.
// - valid_out = done[head]. Output fields are driven from ROB[head].
//   Earliest output handshake for an op accepted at edge n: edge n+STAGES+1.
// - valid_out & ready_in at an edge: clear done[head], head++ mod ROB_DEPTH.
// - Output hold: while valid_out=1 and ready_in=0, all output fields are held stable.
//   valid_out never drops without a handshake.
// - in_flight counts accepted-but-not-drained ops.
//   Accept+drain on the same edge: unchanged. Accept only: +1. Drain only: -1.
//   When full (in_flight=ROB_DEPTH), a drain frees a slot; ready_out=1 on the next cycle (no combinational ready path).
// - Pointer wrap: tail/head wrap at ROB_DEPTH; full vs empty is resolved by in_flight, not pointer compare.
// - Ordering: outputs appear in exact acceptance order.
//   A fast add behind a slow mul waits in the ROB until the mul drains.
// - sub: a + ~b + 1. Overflow when the operand signs differ and the result sign != sign of a.
// - add: overflow when the operands share a sign and the result sign differs.
// - mul: result = low WIDTH bits of the 2*WIDTH product; overflow = |high WIDTH bits.
// TESTING (WIDTH=32, ADD_STAGES=2, MUL_STAGES=3, ROB_DEPTH=8)
// - Single add 5+7 accepted edge 0, ready_in=1 -> valid_out first high after edge 2;
//   result=12, op_out=00, overflow=0, illegal=0.
// - Mul 3*4 at edge 0, then add 1+1 at edge 1 -> add done at edge 3 but held;
//   outputs are 12 (op 10) then 2 (op 00), in that order.
// - Hold ready_in=0 and issue 8 ops -> ready_out=0 with in_flight=8.
//   Then ready_in=1 -> one drain per cycle; ready_out=1 the cycle after the first drain.
//   All 8 results arrive in order, including across the tag wrap.
// - Overflow cases:
//   add 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
//   sub 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
//   mul 0x10000*0x10000 -> 0, overflow=1.
//   op 11 -> result 0, illegal=1.
// - Continuous random traffic with random ready_in for 10k ops against a golden in-order queue:
//   no loss, no duplication, no reorder; outputs stable under backpressure.
// - Assert reset with 5 ops in flight -> outputs 0 immediately.
//   After release, a new add 2+2 returns 4 with no stale results emitted.

Source files
------------

// File: rtl/ordered_dynamic_alu.sv
// ordered_dynamic_alu
//   Latency-insensitive add/sub/mul ALU with ready-valid handshakes on both
//   sides. Ops enter fixed-latency, non-stalling pipes, and results land in a
//   reorder buffer. They leave strictly in acceptance order.
// Ports:
//   clk, reset (async, active-low)
//   operand_a/operand_b/operation/valid_in -> ready_out : issue side
//   result/op_out/overflow/illegal/valid_out <- ready_in : consume side
//   in_flight : accepted-but-not-drained op count
module ordered_dynamic_alu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADD_STAGES = 2,
  parameter int unsigned MUL_STAGES = 3,
  parameter int unsigned ROB_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             operand_a,
  input  logic [WIDTH-1:0]             operand_b,
  input  logic [1:0]                   operation,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [WIDTH-1:0]             result,
  output logic [1:0]                   op_out,
  output logic                         overflow,
  output logic                         illegal,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [$clog2(ROB_DEPTH):0]   in_flight
);

  localparam int unsigned TW = $clog2(ROB_DEPTH);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef struct packed {
    logic            v;
    logic [TW-1:0]   tag;
    logic [1:0]      op;
    logic [WIDTH-1:0] res;
    logic            ovf;
    logic            ill;
  } pipe_t;

  pipe_t add_pipe [ADD_STAGES];
  pipe_t mul_pipe [MUL_STAGES];
  pipe_t add_entry, mul_entry, add_done, mul_done;

  logic [WIDTH-1:0]   rob_res [ROB_DEPTH];
  logic [1:0]         rob_op  [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] rob_ovf, rob_ill, done;

  logic [TW-1:0]      head, tail;
  logic               active;
  logic               accept, drain;
  logic [WIDTH-1:0]   sum, diff;
  logic [2*WIDTH-1:0] prod;

  assign add_done = add_pipe[ADD_STAGES-1];
  assign mul_done = mul_pipe[MUL_STAGES-1];

  // Results are computed at issue; the pipes only delay them to model latency.
  always_comb begin
    add_entry = '0;
    mul_entry = '0;
    sum  = operand_a + operand_b;
    diff = operand_a - operand_b;
    prod = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};
    accept = valid_in & ready_out;
    drain  = valid_out & ready_in;

    add_entry.v   = accept && (op_e'(operation) != OP_MUL);
    add_entry.tag = tail;
    add_entry.op  = operation;
    case (op_e'(operation))
      OP_ADD: begin
        add_entry.res = sum;
        add_entry.ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        add_entry.res = diff;
        add_entry.ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                        (diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_RSV:  add_entry.ill = 1'b1;
      default: ;
    endcase

    mul_entry.v   = accept && (op_e'(operation) == OP_MUL);
    mul_entry.tag = tail;
    mul_entry.op  = operation;
    mul_entry.res = prod[WIDTH-1:0];
    mul_entry.ovf = |prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      head      <= '0;
      tail      <= '0;
      in_flight <= '0;
      done      <= '0;
      for (int unsigned i = 0; i < ADD_STAGES; i++) add_pipe[i] <= '0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else begin
      active      <= 1'b1;
      add_pipe[0] <= add_entry;
      mul_pipe[0] <= mul_entry;
      for (int unsigned i = 1; i < ADD_STAGES; i++) add_pipe[i] <= add_pipe[i-1];
      for (int unsigned i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];

      if (accept) tail <= tail + TW'(1);
      if (drain)  head <= head + TW'(1);

      case ({accept, drain})
        2'b10:   in_flight <= in_flight + (TW+1)'(1);
        2'b01:   in_flight <= in_flight - (TW+1)'(1);
        default: ;
      endcase

      // Completing tags are always in flight and never equal head while head
      // is being drained, so these bit updates never collide.
      if (add_done.v) done[add_done.tag] <= 1'b1;
      if (mul_done.v) done[mul_done.tag] <= 1'b1;
      if (drain)      done[head]         <= 1'b0;
    end
  end

  // Payload storage needs no reset: it is only visible when done[head] is set.
  always_ff @(posedge clk) begin
    if (add_done.v) begin
      rob_res[add_done.tag] <= add_done.res;
      rob_op[add_done.tag]  <= add_done.op;
      rob_ovf[add_done.tag] <= add_done.ovf;
      rob_ill[add_done.tag] <= add_done.ill;
    end
    if (mul_done.v) begin
      rob_res[mul_done.tag] <= mul_done.res;
      rob_op[mul_done.tag]  <= mul_done.op;
      rob_ovf[mul_done.tag] <= mul_done.ovf;
      rob_ill[mul_done.tag] <= mul_done.ill;
    end
  end

  always_comb begin
    valid_out = done[head];
    result    = valid_out ? rob_res[head] : '0;
    op_out    = valid_out ? rob_op[head]  : '0;
    overflow  = valid_out & rob_ovf[head];
    illegal   = valid_out & rob_ill[head];
    ready_out = active && (in_flight < (TW+1)'(ROB_DEPTH));
  end

endmodule
